// File: rtl/bnn_pkg.sv
// bnn_pkg: shared state encoding, width legality check and weight reset default
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam bit W_INIT_BIT = 1'b1;

    function automatic bit acc_w_ok(int data_w, int taps, int acc_w);
        return acc_w >= data_w + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/bnn_conv_stream_if.sv
// bnn_conv_stream_if: input frame and output result streams with valid/ready
interface bnn_conv_stream_if #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 5,
    parameter int KERNELS = 3,
    parameter int ACC_W   = 32
);

    logic                       in_valid;
    logic                       in_ready;
    logic [TAPS*DATA_W-1:0]     in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [KERNELS*ACC_W-1:0]   out_data;
    logic [KERNELS-1:0]         out_sign;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sign
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sign
    );

endinterface

// File: rtl/bnn_dot_pm1.sv
// bnn_dot_pm1: one kernel's +1/-1 weighted sum of a frame
module bnn_dot_pm1 #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 5,
    parameter int ACC_W  = 32
) (
    input  logic [TAPS*DATA_W-1:0] x,
    input  logic [TAPS-1:0]        w,
    output logic signed [ACC_W-1:0] y
);

    logic signed [ACC_W-1:0] xe;

    // widen each tap before negating so the most negative sample flips exactly
    always_comb begin
        y  = '0;
        xe = '0;
        for (int t = 0; t < TAPS; t++) begin
            xe = ACC_W'(signed'(x[t*DATA_W +: DATA_W]));
            y  = w[t] ? y + xe : y - xe;
        end
    end

endmodule

// File: rtl/bnn_conv_stream.sv
// bnn_conv_stream: streaming binary-weight 1-D convolution over a fixed-length run
module bnn_conv_stream
    import bnn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 5,
    parameter int KERNELS = 3,
    parameter int ACC_W   = 32,
    parameter int FRAMES  = 36,
    parameter logic [KERNELS*TAPS-1:0] W_INIT = {KERNELS*TAPS{W_INIT_BIT}}
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    input  logic                                          w_we,
    input  logic [(KERNELS > 1 ? $clog2(KERNELS) : 1)-1:0] w_kidx,
    input  logic [TAPS-1:0]                               w_bits,
    output logic                                          conv_done,
    bnn_conv_stream_if.slave                              s
);

    localparam int CW = FRAMES > 1 ? $clog2(FRAMES) : 1;

    if (!acc_w_ok(DATA_W, TAPS, ACC_W)) begin : g_acc_w_check
        $error("bnn_conv_stream: ACC_W too narrow for DATA_W and TAPS");
    end

    state_t                           state;
    logic [KERNELS-1:0][TAPS-1:0]     wts;
    logic [CW-1:0]                    cnt;
    logic                             ov;
    logic [KERNELS*ACC_W-1:0]         od;
    logic [KERNELS-1:0]               os;
    logic [KERNELS*ACC_W-1:0]         yd;
    logic [KERNELS-1:0]               ys;
    logic                             acc;

    for (genvar k = 0; k < KERNELS; k++) begin : g_kern
        logic signed [ACC_W-1:0] y;
        bnn_dot_pm1 #(.DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W)) u_dot (
            .x (s.in_data),
            .w (wts[k]),
            .y (y)
        );
        assign yd[k*ACC_W +: ACC_W] = y;
        assign ys[k]                = ~y[ACC_W-1];
    end

    assign s.in_ready  = (state == RUN) && (!ov || s.out_ready);
    assign acc         = s.in_valid && s.in_ready;
    assign busy        = state != IDLE;
    assign s.out_valid = ov;
    assign s.out_data  = od;
    assign s.out_sign  = os;

    // run sequencing, weight bank, frame count and the one-deep result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wts       <= W_INIT;
            cnt       <= '0;
            ov        <= 1'b0;
            od        <= '0;
            os        <= '1;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            if (acc) begin
                ov <= 1'b1;
                od <= yd;
                os <= ys;
            end else if (s.out_ready) begin
                ov <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (w_we && 32'(w_kidx) < KERNELS) wts[w_kidx] <= w_bits;
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (acc) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(FRAMES - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ov && s.out_ready) begin
                        state     <= IDLE;
                        conv_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_conv_stream.sv
// tb_bnn_conv_stream: directed checks of arithmetic, streaming, run control and reset abort
module tb_bnn_conv_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       w_we;
    logic [1:0] w_kidx;
    logic [4:0] w_bits;
    logic       conv_done;
    int         total = 0;
    int         pass = 0;
    logic [4:0] mw [3];

    bnn_conv_stream_if #(.DATA_W(16), .TAPS(5), .KERNELS(3), .ACC_W(32)) s ();

    bnn_conv_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .w_we      (w_we),
        .w_kidx    (w_kidx),
        .w_bits    (w_bits),
        .conv_done (conv_done),
        .s         (s)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] pack5(int a, int b, int c, int d, int e);
        return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [95:0] pack3(int a, int b, int c);
        return {32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [79:0] frame(int i);
        logic [79:0] f;
        for (int t = 0; t < 5; t++) f[t*16 +: 16] = 16'(i * 7 + t * 3 - 60);
        return f;
    endfunction

    function automatic logic [95:0] model(logic [79:0] x);
        logic [95:0] r;
        int a;
        for (int k = 0; k < 3; k++) begin
            a = 0;
            for (int t = 0; t < 5; t++)
                a = mw[k][t] ? a + int'($signed(x[t*16 +: 16])) : a - int'($signed(x[t*16 +: 16]));
            r[k*32 +: 32] = 32'(a);
        end
        return r;
    endfunction

    function automatic logic [2:0] sign_of(logic [95:0] r);
        return {~r[95], ~r[63], ~r[31]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        w_we = 1'b0;
        w_kidx = '0;
        w_bits = '0;
        s.in_valid = 1'b0;
        s.in_data = '0;
        s.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [1:0] k, input logic [4:0] b);
        w_we = 1'b1;
        w_kidx = k;
        w_bits = b;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_one(input logic [79:0] x);
        s.in_valid = 1'b1;
        s.in_data = x;
        s.out_ready = 1'b1;
        @(negedge clk);
        s.in_valid = 1'b0;
    endtask

    task automatic run_stream(input bit rnd, input int inj);
        int sent = 0;
        int recv = 0;
        int viol = 0;
        int early = 0;
        int cyc = 0;
        while (recv < 36 && cyc < 2000) begin
            s.out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            s.in_valid = (sent < 36) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            s.in_data = frame(sent);
            w_we = (cyc == inj);
            start = (cyc == inj);
            w_kidx = 2'd0;
            w_bits = 5'b00000;
            #1;
            if (s.out_valid && !s.out_ready && s.in_ready) viol++;
            if (conv_done) early++;
            if (s.out_valid && s.out_ready) begin
                total++;
                if (s.out_data !== model(frame(recv)))
                    $display("FAIL stream_data[%0d]: got %h want %h", recv, s.out_data, model(frame(recv)));
                else pass++;
                total++;
                if (s.out_sign !== sign_of(model(frame(recv))))
                    $display("FAIL stream_sign[%0d]: got %b want %b", recv, s.out_sign, sign_of(model(frame(recv))));
                else pass++;
                recv++;
            end
            if (s.in_valid && s.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        s.in_valid = 1'b0;
        w_we = 1'b0;
        start = 1'b0;
        total++;
        if (recv !== 36) $display("FAIL stream_count: got %0d want 36", recv); else pass++;
        total++;
        if (sent !== 36) $display("FAIL stream_sent: got %0d want 36", sent); else pass++;
        total++;
        if (viol !== 0) $display("FAIL ready_backpressure: got %0d violations want 0", viol); else pass++;
        total++;
        if (early !== 0) $display("FAIL done_early: got %0d pulses want 0", early); else pass++;
        total++;
        if (conv_done !== 1'b1) $display("FAIL done_pulse: got %b want 1", conv_done); else pass++;
        total++;
        if (busy !== 1'b0) $display("FAIL done_busy: got %b want 0", busy); else pass++;
        total++;
        if (s.out_valid !== 1'b0) $display("FAIL done_out_valid: got %b want 0", s.out_valid); else pass++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        total++;
        if (s.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", s.in_ready); else pass++;
        total++;
        if (s.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", s.out_valid); else pass++;
        total++;
        if (conv_done !== 1'b0) $display("FAIL reset_conv_done: got %b want 0", conv_done); else pass++;
        total++;
        if (s.out_data !== 96'd0) $display("FAIL reset_out_data: got %h want 0", s.out_data); else pass++;
        total++;
        if (s.out_sign !== 3'b111) $display("FAIL reset_out_sign: got %b want 111", s.out_sign); else pass++;
    endtask

    task automatic test_default_weights();
        do_reset();
        start_run();
        total++;
        if (busy !== 1'b1) $display("FAIL run_busy: got %b want 1", busy); else pass++;
        total++;
        if (s.in_ready !== 1'b1) $display("FAIL run_in_ready: got %b want 1", s.in_ready); else pass++;
        send_one(pack5(1, 2, 3, 4, 5));
        total++;
        if (s.out_valid !== 1'b1) $display("FAIL default_valid: got %b want 1", s.out_valid); else pass++;
        total++;
        if (s.out_data !== pack3(15, 15, 15)) $display("FAIL default_data: got %h want %h", s.out_data, pack3(15, 15, 15)); else pass++;
        total++;
        if (s.out_sign !== 3'b111) $display("FAIL default_sign: got %b want 111", s.out_sign); else pass++;
        s.out_ready = 1'b0;
        #1;
        total++;
        if (s.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", s.in_ready); else pass++;
    endtask

    task automatic test_loaded_weights();
        do_reset();
        load(2'd0, 5'b11101);
        load(2'd1, 5'b00000);
        load(2'd2, 5'b11111);
        load(2'd3, 5'b00000);
        start_run();
        send_one(pack5(1, 2, 3, 4, 5));
        total++;
        if (s.out_data !== pack3(11, -15, 15)) $display("FAIL loaded_data: got %h want %h", s.out_data, pack3(11, -15, 15)); else pass++;
        total++;
        if (s.out_sign !== 3'b101) $display("FAIL loaded_sign: got %b want 101", s.out_sign); else pass++;
    endtask

    task automatic test_extremes();
        do_reset();
        load(2'd0, 5'b00000);
        load(2'd1, 5'b00000);
        load(2'd2, 5'b00000);
        start_run();
        send_one(pack5(-32768, -32768, -32768, -32768, -32768));
        total++;
        if (s.out_data !== pack3(163840, 163840, 163840)) $display("FAIL extreme_neg: got %h want %h", s.out_data, pack3(163840, 163840, 163840)); else pass++;
        total++;
        if (s.out_sign !== 3'b111) $display("FAIL extreme_neg_sign: got %b want 111", s.out_sign); else pass++;
        do_reset();
        start_run();
        send_one(pack5(32767, 32767, 32767, 32767, 32767));
        total++;
        if (s.out_data !== pack3(163835, 163835, 163835)) $display("FAIL extreme_pos: got %h want %h", s.out_data, pack3(163835, 163835, 163835)); else pass++;
    endtask

    task automatic test_full_run();
        do_reset();
        load(2'd1, 5'b00000);
        load(2'd2, 5'b10110);
        mw[0] = 5'b11111;
        mw[1] = 5'b00000;
        mw[2] = 5'b10110;
        start_run();
        run_stream(1'b1, -1);
        s.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (conv_done !== 1'b0) $display("FAIL done_single: got %b want 0", conv_done); else pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mw[0] = 5'b11111;
        mw[1] = 5'b11111;
        mw[2] = 5'b11111;
        start_run();
        run_stream(1'b0, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL restart_busy: got %b want 1", busy); else pass++;
        total++;
        if (conv_done !== 1'b0) $display("FAIL restart_done: got %b want 0", conv_done); else pass++;
        send_one(pack5(1, 2, 3, 4, 5));
        total++;
        if (s.out_data !== pack3(15, 15, 15)) $display("FAIL midrun_write: got %h want %h", s.out_data, pack3(15, 15, 15)); else pass++;
    endtask

    task automatic test_reset_abort();
        do_reset();
        load(2'd1, 5'b00000);
        start_run();
        s.in_valid = 1'b1;
        s.in_data = pack5(1, 2, 3, 4, 5);
        s.out_ready = 1'b0;
        @(negedge clk);
        s.in_valid = 1'b0;
        total++;
        if (s.out_valid !== 1'b1) $display("FAIL abort_pre_valid: got %b want 1", s.out_valid); else pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass++;
        total++;
        if (s.out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", s.out_valid); else pass++;
        total++;
        if (s.in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", s.in_ready); else pass++;
        total++;
        if (conv_done !== 1'b0) $display("FAIL abort_done: got %b want 0", conv_done); else pass++;
        @(negedge clk);
        total++;
        if (conv_done !== 1'b0) $display("FAIL abort_done_late: got %b want 0", conv_done); else pass++;
        start_run();
        send_one(pack5(1, 2, 3, 4, 5));
        total++;
        if (s.out_data !== pack3(15, 15, 15)) $display("FAIL abort_weights: got %h want %h", s.out_data, pack3(15, 15, 15)); else pass++;
    endtask

    initial begin
        test_reset();
        test_default_weights();
        test_loaded_weights();
        test_extremes();
        test_full_run();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
